// File: rtl/ruta_datos_muldiv.sv
// ruta_datos_muldiv: shift-add multiply / divide datapath driven by an external controller word.
// Registers update on the rising edge of reloj; status flags are combinational from the registers.
module ruta_datos_muldiv (
    input  logic        reloj,
    input  logic        reset,
    input  logic [17:0] estado,
    input  logic [15:0] operando1,
    input  logic [15:0] operando2,
    output logic        AEScero,
    output logic        A0EScero,
    output logic        CNOcero,
    output logic        neg1,
    output logic        neg2,
    output logic        neg1IGUALneg2,
    output logic        contNOquince,
    output logic        neg_reg_C_MSB,
    output logic        divcero,
    output logic [15:0] resultado_alto,
    output logic [15:0] resultado_bajo,
    output logic        listo
);
    logic [15:0] r_r1, r_r2, r_c, r_res_hi, r_res_lo;
    logic [16:0] r_a;
    logic [3:0]  r_cont;
    logic        r_neg1, r_neg2, r_listo;
    logic [31:0] w_neg_ac;
    logic [16:0] w_a_next;
    logic [15:0] w_c_next;
    logic        w_unused_estado;

    assign w_unused_estado = ^estado[17:15];
    assign w_neg_ac = -{r_a[15:0], r_c};

    // Shifts and the 32-bit negate claim A and C together, so both chains share their top levels
    always_comb begin
        w_a_next = estado[0]  ? 17'd0 :
                   estado[9]  ? {1'b0, w_neg_ac[31:16]} :
                   estado[3]  ? {r_a[15:0], r_c[15]} :
                   estado[4]  ? {1'b0, r_a[16:1]} :
                   estado[5]  ? r_a + {1'b0, r_r2} :
                   estado[6]  ? r_a - {1'b0, r_r2} :
                   estado[11] ? {1'b0, -r_a[15:0]} : r_a;
        w_c_next = estado[0]  ? 16'd0 :
                   estado[9]  ? w_neg_ac[15:0] :
                   estado[3]  ? {r_c[14:0], 1'b0} :
                   estado[4]  ? {r_a[0], r_c[15:1]} :
                   estado[12] ? r_r1 :
                   estado[10] ? -r_c :
                   estado[7]  ? (r_c | 16'd1) : r_c;
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_c      <= '0;
            r_r1     <= '0;
            r_r2     <= '0;
            r_cont   <= '0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_listo  <= 1'b0;
        end else begin
            r_a    <= w_a_next;
            r_c    <= w_c_next;
            r_r1   <= estado[0] ? operando1 : estado[1] ? -r_r1 : r_r1;
            r_r2   <= estado[0] ? operando2 : estado[2] ? -r_r2 : r_r2;
            r_neg1 <= estado[0] ? operando1[15] : r_neg1;
            r_neg2 <= estado[0] ? operando2[15] : r_neg2;
            r_cont <= estado[0] ? 4'd0 : estado[8] ? r_cont + 4'd1 : r_cont;
            if (estado[14]) begin
                r_res_hi <= r_a[15:0];
                r_res_lo <= r_c;
            end
            r_listo <= estado[13];
        end
    end

    assign AEScero        = (r_a == 17'd0);
    assign A0EScero       = ~r_c[0];
    assign CNOcero        = (r_c != 16'd0);
    assign neg1           = r_neg1;
    assign neg2           = r_neg2;
    assign neg1IGUALneg2  = (r_neg1 == r_neg2);
    assign contNOquince   = (r_cont != 4'd15);
    assign neg_reg_C_MSB  = r_a[16];
    assign divcero        = (r_r2 == 16'd0);
    assign resultado_alto = r_res_hi;
    assign resultado_bajo = r_res_lo;
    assign listo          = r_listo;
endmodule
